// File: rtl/fetch_issue_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_issue_ctrl
//  Purpose  : Fetch sequencer and in-order issue front end for a Tomasulo
//             core. Drives the PC into a 1-cycle registered instruction
//             memory and captures the returned 16-bit words in a small
//             circular queue. Each queue head is steered to the add or the
//             mul reservation-station group. Fetching stops at PROG_LEN or
//             when a HALT word (op 4'hF) returns.
//  Ports    : clk1, reset (async, active-high), restart (sync flush)
//             pc            -> fetch address
//             imem_instr    <- memory data, [15:0] valid 1 cycle after pc
//             add_rs_free / mul_rs_free <- reservation group has room
//             issue_valid / issue_instr / issue_unit -> issue handshake
//             done          -> program fully fetched and issued
//             stall_cnt     -> head-blocked cycle counter (optional)
//  Options  : `define ISSUE_STALL_CNT_EN builds the saturating stall counter;
//             otherwise stall_cnt is tied to zero.
//  Revision : 1.0 - initial release
// ============================================================================
module fetch_issue_ctrl #(
    parameter int QDEPTH   = 4,
    parameter int PROG_LEN = 6,
    parameter int PCW      = 32
) (
    input  logic           clk1,
    input  logic           reset,
    input  logic           restart,
    output logic [PCW-1:0] pc,
    input  logic [31:0]    imem_instr,
    input  logic           add_rs_free,
    input  logic           mul_rs_free,
    output logic           issue_valid,
    output logic [15:0]    issue_instr,
    output logic           issue_unit,
    output logic           done,
    output logic [15:0]    stall_cnt
);

    localparam int AW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [3:0]     C_OP_HALT = 4'hF;
    localparam logic [PCW-1:0] C_PC_END  = PCW'(PROG_LEN);
    localparam logic [CW-1:0]  C_Q_FULL  = CW'(QDEPTH);

    // ops 0010/0011 go to the mul group; everything else to the add group
    function automatic logic decode_unit(input logic [15:0] instr);
        return (instr[15:12] == 4'h2) || (instr[15:12] == 4'h3);
    endfunction

    logic [PCW-1:0] pc_q, pc_d;
    logic           fetch_pending_q, fetch_pending_d;
    logic           fetch_stop_q, fetch_stop_d;
    logic           done_q, done_d;
    logic [AW-1:0]  head_q, head_d;
    logic [AW-1:0]  tail_q, tail_d;
    logic [CW-1:0]  count_q, count_d;
    logic [15:0]    queue_mem [QDEPTH];

    logic           q_empty;
    logic [15:0]    head_instr;
    logic           head_unit;
    logic           ret_halt;
    logic           launch;
    logic           push;
    logic           pop;
    logic           unused_imem_hi;

    assign unused_imem_hi = ^imem_instr[31:16];

    always_comb begin
        q_empty    = (count_q == '0);
        head_instr = queue_mem[head_q];
        head_unit  = decode_unit(head_instr);
        // a returning HALT also blocks a same-cycle launch so pc holds
        ret_halt   = fetch_pending_q && (imem_instr[15:12] == C_OP_HALT);
        // count + pending reserves a slot for the word still in flight,
        // so a push can never hit a full queue
        launch     = !restart && !fetch_stop_q && !ret_halt &&
                     (pc_q < C_PC_END) &&
                     ((count_q + CW'(fetch_pending_q)) < C_Q_FULL);
        push       = fetch_pending_q && !ret_halt && !restart;
        pop        = !restart && !q_empty &&
                     (head_unit ? mul_rs_free : add_rs_free);
    end

    always_comb begin
        pc_d            = pc_q;
        fetch_pending_d = fetch_pending_q;
        fetch_stop_d    = fetch_stop_q;
        done_d          = done_q;
        head_d          = head_q;
        tail_d          = tail_q;
        count_d         = count_q;
        if (restart) begin
            // the squashed fetch's data is ignored because pending clears
            pc_d            = '0;
            fetch_pending_d = 1'b0;
            fetch_stop_d    = 1'b0;
            done_d          = 1'b0;
            head_d          = '0;
            tail_d          = '0;
            count_d         = '0;
        end else begin
            if (launch) begin
                pc_d = pc_q + PCW'(1);
            end
            fetch_pending_d = launch;
            if (ret_halt || (pc_q == C_PC_END)) begin
                fetch_stop_d = 1'b1;
            end
            if (push) begin
                tail_d = tail_q + AW'(1);
            end
            if (pop) begin
                head_d = head_q + AW'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
            if (fetch_stop_q && !fetch_pending_q && q_empty) begin
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk1 or posedge reset) begin
        if (reset) begin
            pc_q            <= '0;
            fetch_pending_q <= 1'b0;
            fetch_stop_q    <= 1'b0;
            done_q          <= 1'b0;
            head_q          <= '0;
            tail_q          <= '0;
            count_q         <= '0;
        end else begin
            pc_q            <= pc_d;
            fetch_pending_q <= fetch_pending_d;
            fetch_stop_q    <= fetch_stop_d;
            done_q          <= done_d;
            head_q          <= head_d;
            tail_q          <= tail_d;
            count_q         <= count_d;
        end
    end

    // storage needs no reset: a slot is only read after it has been written
    always_ff @(posedge clk1) begin
        if (push) begin
            queue_mem[tail_q] <= imem_instr[15:0];
        end
    end

    assign pc          = pc_q;
    assign done        = done_q;
    assign issue_valid = pop;
    assign issue_instr = q_empty ? 16'h0000 : head_instr;
    assign issue_unit  = q_empty ? 1'b0 : head_unit;

`ifdef ISSUE_STALL_CNT_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (restart) begin
            stall_cnt_d = '0;
        end else if (!q_empty && !pop && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk1 or posedge reset) begin
        if (reset) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`else
    assign stall_cnt = 16'h0000;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_issue_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fetch_issue_ctrl
//  Purpose  : Scoreboard bench for fetch_issue_ctrl. The expected issue
//             stream is derived from the program image (words in order up
//             to the first HALT, each with its decoded unit) and queued.
//             A monitor pops and compares on every issue_valid.
//  Options  : honours `define ISSUE_STALL_CNT_EN for the stall counter check.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_issue_ctrl;

    localparam int QDEPTH   = 4;
    localparam int PROG_LEN = 6;
    localparam int PCW      = 32;

    logic           clk1 = 1'b0;
    logic           reset = 1'b0;
    logic           restart = 1'b0;
    logic [PCW-1:0] pc;
    logic [31:0]    imem_instr = 32'h0;
    logic           add_rs_free = 1'b1;
    logic           mul_rs_free = 1'b1;
    logic           issue_valid;
    logic [15:0]    issue_instr;
    logic           issue_unit;
    logic           done;
    logic [15:0]    stall_cnt;

    fetch_issue_ctrl #(.QDEPTH(QDEPTH), .PROG_LEN(PROG_LEN), .PCW(PCW)) dut (
        .clk1(clk1), .reset(reset), .restart(restart), .pc(pc),
        .imem_instr(imem_instr), .add_rs_free(add_rs_free),
        .mul_rs_free(mul_rs_free), .issue_valid(issue_valid),
        .issue_instr(issue_instr), .issue_unit(issue_unit), .done(done),
        .stall_cnt(stall_cnt)
    );

    always #5 clk1 = ~clk1;

    typedef struct packed {
        logic [15:0] instr;
        logic        unit;
    } exp_t;

    logic [15:0] prog [PROG_LEN];
    exp_t        exp_q[$];
    exp_t        mon_e;
    int          n_chk = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          last_issue_cyc = 0;
    bit          rand_free = 1'b0;

    // registered-read instruction memory with junk in the upper half
    always @(posedge clk1) begin
        if (int'(pc) < PROG_LEN) imem_instr <= {16'($urandom), prog[int'(pc)]};
        else                     imem_instr <= {16'($urandom), 16'h0000};
    end

    always @(posedge clk1) cyc <= cyc + 1;

    always @(posedge clk1) begin
        if (rand_free) begin
            #1;
            add_rs_free = ($urandom_range(0, 3) != 0);
            mul_rs_free = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    function automatic logic unit_of(input logic [15:0] w);
        logic [3:0] op;
        op = w[15:12];
        return (op == 4'd2) || (op == 4'd3);
    endfunction

    // reference: program order, truncated at the first HALT
    task automatic load_expected();
        exp_t e;
        exp_q.delete();
        for (int i = 0; i < PROG_LEN; i++) begin
            if (prog[i][15:12] == 4'hF) break;
            e.instr = prog[i];
            e.unit  = unit_of(prog[i]);
            exp_q.push_back(e);
        end
    endtask

    function automatic int expected_pc();
        for (int i = 0; i < PROG_LEN; i++)
            if (prog[i][15:12] == 4'hF) return i + 1;
        return PROG_LEN;
    endfunction

    task automatic set_prog(input logic [15:0] w0, w1, w2, w3, w4, w5);
        prog[0] = w0; prog[1] = w1; prog[2] = w2;
        prog[3] = w3; prog[4] = w4; prog[5] = w5;
    endtask

    // monitor: every accepted issue must match the next expected word
    always @(negedge clk1) begin
        if (!reset && issue_valid) begin
            last_issue_cyc = cyc;
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_issue: actual=0x%0h required=none", issue_instr);
            end else begin
                mon_e = exp_q.pop_front();
                chk("issue_instr", 32'(issue_instr), 32'(mon_e.instr));
                chk("issue_unit", 32'(issue_unit), 32'(mon_e.unit));
                chk("issue_unit_free", 32'(mon_e.unit ? mul_rs_free : add_rs_free), 32'd1);
            end
        end
    end

    task automatic apply_reset();
        restart = 1'b0;
        reset   = 1'b1;
        @(posedge clk1);
        @(posedge clk1);
        #1;
        chk("reset_pc", pc, 32'd0);
        chk("reset_issue_valid", 32'(issue_valid), 32'd0);
        chk("reset_issue_instr", 32'(issue_instr), 32'd0);
        chk("reset_issue_unit", 32'(issue_unit), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_stall_cnt", 32'(stall_cnt), 32'd0);
        reset = 1'b0;
    endtask

    task automatic run_to_done(input string tag, input int exp_pc);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk1);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            n_chk++;
            n_fail++;
            $display("FAIL %s_done_timeout: actual=0 required=1", tag);
        end
        chk({tag, "_all_issued"}, 32'(exp_q.size()), 32'd0);
        chk({tag, "_final_pc"}, pc, 32'(exp_pc));
    endtask

    initial begin
        set_prog(16'h2123, 16'h0345, 16'h0267, 16'h089A, 16'h27AB, 16'h0000);
        #1;

        // basic program, everything free
        add_rs_free = 1'b1; mul_rs_free = 1'b1;
        load_expected();
        apply_reset();
        for (int k = 0; k <= PROG_LEN; k++) begin
            @(negedge clk1);
            chk("pc_step", pc, 32'(k));
        end
        run_to_done("basic", PROG_LEN);
        chk("done_latency", 32'(cyc - last_issue_cyc), 32'd2);
        chk("basic_stall_cnt", 32'(stall_cnt), 32'd0);

        // head blocked on mul group: queue fills, pc stops at QDEPTH
        mul_rs_free = 1'b0;
        load_expected();
        apply_reset();
        repeat (12) @(negedge clk1);
        chk("blocked_pc", pc, 32'(QDEPTH));
        chk("blocked_issue_valid", 32'(issue_valid), 32'd0);
        chk("blocked_head", 32'(issue_instr), 32'h2123);
        chk("blocked_nothing_issued", 32'(exp_q.size()), 32'd6);
        mul_rs_free = 1'b1;
        run_to_done("blocked", PROG_LEN);

        // HALT as word 2
        set_prog(16'h2123, 16'h0345, 16'hF000, 16'h089A, 16'h27AB, 16'h0000);
        load_expected();
        apply_reset();
        run_to_done("halt", 3);
        repeat (3) @(negedge clk1);
        chk("halt_pc_holds", pc, 32'd3);
        chk("halt_done_holds", 32'(done), 32'd1);

        // restart while 3 entries are queued and a fetch is in flight
        set_prog(16'h2123, 16'h0345, 16'h0267, 16'h089A, 16'h27AB, 16'h0000);
        mul_rs_free = 1'b0;
        load_expected();
        apply_reset();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk1);
            if (pc == 32'd3) break;
        end
        @(posedge clk1);
        #1;
        chk("pre_restart_pc", pc, 32'd4);
        restart = 1'b1;
        @(posedge clk1);
        #1;
        restart = 1'b0;
        @(negedge clk1);
        chk("restart_pc", pc, 32'd0);
        chk("restart_issue_valid", 32'(issue_valid), 32'd0);
        chk("restart_queue_empty", 32'(issue_instr), 32'd0);
        load_expected();
        mul_rs_free = 1'b1;
        run_to_done("restart", PROG_LEN);

        // async reset between clock edges mid-run, then after done
        load_expected();
        apply_reset();
        repeat (4) @(posedge clk1);
        #3;
        reset = 1'b1;
        #1;
        chk("async_pc", pc, 32'd0);
        chk("async_issue_valid", 32'(issue_valid), 32'd0);
        chk("async_done", 32'(done), 32'd0);
        load_expected();
        @(posedge clk1);
        #1;
        reset = 1'b0;
        run_to_done("after_async", PROG_LEN);
        #2;
        reset = 1'b1;
        #1;
        chk("async_done_clear", 32'(done), 32'd0);
        chk("async_pc_clear", pc, 32'd0);
        @(posedge clk1);
        #1;
        reset = 1'b0;

        // add group held off for 5 cycles while 0x0345 is at the head
        add_rs_free = 1'b0; mul_rs_free = 1'b1;
        load_expected();
        apply_reset();
        for (int i = 0; i < 50; i++) begin
            @(negedge clk1);
            if (issue_instr == 16'h0345 && !issue_valid) break;
        end
        repeat (5) @(posedge clk1);
        #1;
        add_rs_free = 1'b1;
        run_to_done("stall", PROG_LEN);
`ifdef ISSUE_STALL_CNT_EN
        chk("stall_cnt", 32'(stall_cnt), 32'd5);
`else
        chk("stall_cnt_tied", 32'(stall_cnt), 32'd0);
`endif

        // random programs with random reservation availability
        for (int it = 0; it < 25; it++) begin
            for (int i = 0; i < PROG_LEN; i++) begin
                if ($urandom_range(0, 15) == 0) prog[i] = {4'hF, 12'($urandom)};
                else prog[i] = {4'($urandom_range(0, 14)), 12'($urandom)};
            end
            load_expected();
            apply_reset();
            rand_free = 1'b1;
            run_to_done("random", expected_pc());
            rand_free = 1'b0;
            @(posedge clk1);
            #2;
            add_rs_free = 1'b1; mul_rs_free = 1'b1;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
